// File: rtl/vga_stream_pkg.sv
// Shared video-stream types for the frame-capture sink: frame geometry,
// 30-bit pixel layout, RGB222 quantiser and capture FSM states.
package vga_stream_pkg;

    localparam int unsigned H_PIXELS   = 640;
    localparam int unsigned V_PIXELS   = 480;
    localparam int unsigned NUM_PIXELS = H_PIXELS * V_PIXELS;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } pixel30_t;

    typedef logic [5:0] rgb222_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOP,
        CAPTURE
    } capture_state_e;

    // Top two bits per channel undo the source's 2-to-10-bit replication.
    function automatic rgb222_t to_rgb222(input pixel30_t p);
        return {p.r[9:8], p.g[9:8], p.b[9:8]};
    endfunction

endpackage

// File: rtl/vga_frame_capture_if.sv
// Avalon-ST 30-bit RGB pixel stream between a video source and a sink.
interface vga_frame_capture_if;

    logic [29:0] data;
    logic        startofpacket;
    logic        endofpacket;
    logic        valid;
    logic        ready;

    modport master (
        output data, startofpacket, endofpacket, valid,
        input  ready
    );

    modport slave (
        input  data, startofpacket, endofpacket, valid,
        output ready
    );

endinterface

// File: rtl/frame_ram_sdp.sv
// Simple dual-port frame RAM: write port driven from registered inputs,
// registered read port with old-data read-during-write behaviour.
module frame_ram_sdp #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 6,
    parameter int unsigned DEPTH  = 307200
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/vga_frame_capture.sv
// Avalon-ST video sink that captures one well-formed frame per host request
// into an RGB222 frame RAM readable through a 1-cycle-latency port.
module vga_frame_capture #(
    parameter int unsigned H_PIXELS = vga_stream_pkg::H_PIXELS,
    parameter int unsigned V_PIXELS = vga_stream_pkg::V_PIXELS,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    vga_frame_capture_if.slave st,
    input  logic              capture_req,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       frame_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [5:0]        rd_data
);

    import vga_stream_pkg::*;

    localparam int unsigned      FRAME_PIXELS = H_PIXELS * V_PIXELS;
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(FRAME_PIXELS - 1);

    capture_state_e    state;
    logic [ADDR_W-1:0] pix_idx;
    logic [ADDR_W-1:0] beat_idx;
    logic              accept;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    rgb222_t           wr_data;

    assign accept   = st.valid && st.ready;
    // A startofpacket beat always lands at address 0, also when resyncing mid-frame.
    assign beat_idx = st.startofpacket ? '0 : pix_idx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            pix_idx     <= '0;
            st.ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            frame_count <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else begin
            st.ready <= 1'b1;
            done     <= 1'b0;
            wr_en    <= 1'b0;
            if (accept && st.endofpacket) begin
                frame_count <= frame_count + 16'd1;
            end
            case (state)
                IDLE: begin
                    // A request landing on the done cycle is dropped.
                    if (capture_req && !done) begin
                        state <= WAIT_SOP;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                    end
                end
                WAIT_SOP, CAPTURE: begin
                    if (accept && (state == CAPTURE || st.startofpacket)) begin
                        wr_en   <= 1'b1;
                        wr_addr <= beat_idx;
                        wr_data <= to_rgb222(pixel30_t'(st.data));
                        if (state == CAPTURE && st.startofpacket) begin
                            err <= 1'b1;
                        end
                        if (beat_idx == LAST_IDX && st.endofpacket) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (beat_idx == LAST_IDX || st.endofpacket) begin
                            err   <= 1'b1;
                            state <= WAIT_SOP;
                        end else begin
                            pix_idx <= beat_idx + 1'b1;
                            state   <= CAPTURE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    frame_ram_sdp #(
        .ADDR_W (ADDR_W),
        .DATA_W (6),
        .DEPTH  (FRAME_PIXELS)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture on a reduced 16x4 frame (64 pixels).
module tb_vga_frame_capture;

    localparam int unsigned H = 16;
    localparam int unsigned V = 4;
    localparam int unsigned AW = 6;
    localparam int NPIX = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          capture_req = 1'b0;
    logic          busy, done, err;
    logic [15:0]   frame_count;
    logic [AW-1:0] rd_addr = '0;
    logic [5:0]    rd_data;

    int checks = 0;
    int errors = 0;
    int exp_fc = 0;

    vga_frame_capture_if st ();

    vga_frame_capture #(
        .H_PIXELS (H),
        .V_PIXELS (V),
        .ADDR_W   (AW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .st          (st.slave),
        .capture_req (capture_req),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .frame_count (frame_count),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] make_pix(input int k);
        logic [5:0] v;
        v = k[5:0];
        return {{5{v[5:4]}}, {5{v[3:2]}}, {5{v[1:0]}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int k, input bit sop, input bit eop);
        st.data          = make_pix(k);
        st.startofpacket = sop;
        st.endofpacket   = eop;
        st.valid         = 1'b1;
        tick();
        if (eop) exp_fc++;
        st.valid         = 1'b0;
        st.startofpacket = 1'b0;
        st.endofpacket   = 1'b0;
    endtask

    // Beat i carries pixel base+i; -1 disables sop_b/eop_at/arm_at.
    task automatic send_frame(input int base, input int nbeats, input int sop_b,
                              input int eop_at, input int arm_at, input bit gaps,
                              output bit ready_dropped);
        ready_dropped = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                tick();
                if (st.ready !== 1'b1) ready_dropped = 1'b1;
            end
            capture_req = (i == arm_at);
            send_beat(base + i, (i == 0) || (i == sop_b), i == eop_at);
            capture_req = 1'b0;
        end
    endtask

    task automatic arm();
        capture_req = 1'b1;
        tick();
        capture_req = 1'b0;
    endtask

    task automatic read_ram(input int a, output logic [5:0] d);
        rd_addr = AW'(a);
        tick();
        d = rd_data;
    endtask

    task automatic test_reset();
        logic [5:0] d;
        st.valid = 1'b0; st.startofpacket = 1'b0; st.endofpacket = 1'b0; st.data = '0;
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({st.ready, busy, done, err} !== 4'b0000 || frame_count !== 16'd0 || rd_data !== 6'd0) begin
            errors++;
            $display("FAIL reset_values: ready=%b busy=%b done=%b err=%b fc=%0d rd=%0h, required all 0",
                     st.ready, busy, done, err, frame_count, rd_data);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (st.ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, required 1", st.ready);
        end
        d = '0;
    endtask

    task automatic test_clean_frame();
        logic [5:0] d;
        bit rd;
        arm();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy: got %b, required 1", busy); end
        send_frame(0, NPIX, -1, NPIX - 1, -1, 1'b0, rd);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_done: done=%b err=%b busy=%b, required 1 0 0", done, err, busy);
        end
        rd_addr = AW'(NPIX - 1);
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL clean_done_single: got %b, required 0", done); end
        read_ram(NPIX - 1, d);
        checks++;
        if (d !== 6'h3F) begin errors++; $display("FAIL clean_last_after_done: got %h, required 3f", d); end
        read_ram(0, d);
        checks++;
        if (d !== 6'h00) begin errors++; $display("FAIL clean_ram0: got %h, required 00", d); end
        read_ram(1, d);
        checks++;
        if (d !== 6'h01) begin errors++; $display("FAIL clean_ram1: got %h, required 01", d); end
        read_ram(37, d);
        checks++;
        if (d !== 6'd37) begin errors++; $display("FAIL clean_ram37: got %h, required 25", d); end
        checks++;
        if (frame_count !== 16'(exp_fc)) begin
            errors++; $display("FAIL clean_fc: got %0d, required %0d", frame_count, exp_fc);
        end
    endtask

    task automatic test_wait_sop();
        logic [5:0] d;
        bit rd;
        int fc_before;
        fc_before = exp_fc;
        send_frame(100, NPIX, -1, NPIX - 1, 20, 1'b0, rd);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL wsop_armed: busy=%b done=%b, required 1 0", busy, done);
        end
        send_frame(200, NPIX, -1, NPIX - 1, -1, 1'b0, rd);
        checks++;
        if (done !== 1'b1 || frame_count !== 16'(fc_before + 2)) begin
            errors++;
            $display("FAIL wsop_done: done=%b fc=%0d, required 1 %0d", done, frame_count, fc_before + 2);
        end
        read_ram(0, d);
        checks++;
        if (d !== 6'd8) begin errors++; $display("FAIL wsop_ram0: got %0d, required 8", d); end
        read_ram(63, d);
        checks++;
        if (d !== 6'd7) begin errors++; $display("FAIL wsop_ram63: got %0d, required 7", d); end
    endtask

    task automatic test_done_collision();
        bit rd;
        arm();
        send_frame(0, NPIX, -1, NPIX - 1, -1, 1'b0, rd);
        capture_req = 1'b1;
        tick();
        capture_req = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL req_on_done: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_early_eop();
        logic [5:0] d;
        bit rd;
        arm();
        send_frame(5, 11, -1, 10, -1, 1'b0, rd);
        checks++;
        if (err !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL early_eop_err: err=%b busy=%b done=%b, required 1 1 0", err, busy, done);
        end
        send_frame(300, NPIX, -1, NPIX - 1, -1, 1'b0, rd);
        checks++;
        if (done !== 1'b1 || err !== 1'b1) begin
            errors++; $display("FAIL early_eop_retry: done=%b err=%b, required 1 1", done, err);
        end
        read_ram(0, d);
        checks++;
        if (d !== 6'd44) begin errors++; $display("FAIL early_eop_ram0: got %0d, required 44", d); end
        read_ram(5, d);
        checks++;
        if (d !== 6'd49) begin errors++; $display("FAIL early_eop_ram5: got %0d, required 49", d); end
        arm();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL err_clear: err=%b busy=%b, required 0 1", err, busy);
        end
    endtask

    task automatic test_mid_sop();
        logic [5:0] d;
        bit rd;
        send_frame(400, NPIX + 10, 10, NPIX + 9, -1, 1'b0, rd);
        checks++;
        if (done !== 1'b1 || err !== 1'b1) begin
            errors++; $display("FAIL mid_sop_done: done=%b err=%b, required 1 1", done, err);
        end
        read_ram(0, d);
        checks++;
        if (d !== 6'd26) begin errors++; $display("FAIL mid_sop_ram0: got %0d, required 26", d); end
        read_ram(5, d);
        checks++;
        if (d !== 6'd31) begin errors++; $display("FAIL mid_sop_ram5: got %0d, required 31", d); end
        read_ram(63, d);
        checks++;
        if (d !== 6'd25) begin errors++; $display("FAIL mid_sop_ram63: got %0d, required 25", d); end
    endtask

    task automatic test_missing_eop();
        bit rd;
        arm();
        send_frame(800, NPIX, -1, -1, -1, 1'b0, rd);
        checks++;
        if (err !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL missing_eop: err=%b busy=%b done=%b, required 1 1 0", err, busy, done);
        end
        send_frame(900, NPIX, -1, NPIX - 1, -1, 1'b0, rd);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL missing_eop_retry: done=%b, required 1", done); end
    endtask

    task automatic test_idle_stall();
        logic [5:0] d;
        bit rd;
        send_frame(7, NPIX, -1, NPIX - 1, -1, 1'b1, rd);
        checks++;
        if (rd || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_stream: ready_dropped=%b done=%b busy=%b, required 0 0 0", rd, done, busy);
        end
        read_ram(0, d);
        checks++;
        if (d !== 6'd4) begin errors++; $display("FAIL idle_no_write0: got %0d, required 4", d); end
        read_ram(63, d);
        checks++;
        if (d !== 6'd3) begin errors++; $display("FAIL idle_no_write63: got %0d, required 3", d); end
        arm();
        send_frame(500, NPIX, -1, NPIX - 1, -1, 1'b1, rd);
        checks++;
        if (rd || done !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL stall_capture: ready_dropped=%b done=%b err=%b, required 0 1 0", rd, done, err);
        end
        read_ram(0, d);
        checks++;
        if (d !== 6'd52) begin errors++; $display("FAIL stall_ram0: got %0d, required 52", d); end
        read_ram(33, d);
        checks++;
        if (d !== 6'd21) begin errors++; $display("FAIL stall_ram33: got %0d, required 21", d); end
        checks++;
        if (frame_count !== 16'(exp_fc)) begin
            errors++; $display("FAIL stall_fc: got %0d, required %0d", frame_count, exp_fc);
        end
    endtask

    task automatic test_reset_mid_capture();
        logic [5:0] d;
        bit rd;
        arm();
        send_frame(600, 30, -1, -1, -1, 1'b0, rd);
        reset_n = 1'b0;
        tick();
        exp_fc = 0;
        checks++;
        if ({st.ready, busy, done, err} !== 4'b0000 || frame_count !== 16'd0 || rd_data !== 6'd0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b busy=%b done=%b err=%b fc=%0d rd=%0h, required all 0",
                     st.ready, busy, done, err, frame_count, rd_data);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_quiet: done=%b busy=%b, required 0 0", done, busy);
        end
        arm();
        send_frame(700, NPIX, -1, NPIX - 1, -1, 1'b0, rd);
        checks++;
        if (done !== 1'b1 || frame_count !== 16'(exp_fc)) begin
            errors++; $display("FAIL reset_recapture: done=%b fc=%0d, required 1 %0d", done, frame_count, exp_fc);
        end
        read_ram(0, d);
        checks++;
        if (d !== 6'd60) begin errors++; $display("FAIL reset_recapture_ram0: got %0d, required 60", d); end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_wait_sop();
        test_done_collision();
        test_early_eop();
        test_mid_sop();
        test_missing_eop();
        test_idle_stall();
        test_reset_mid_capture();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
